// File: rtl/video_fx_pkg.sv
// Shared constants and helpers for the video_mixer_fx pipeline.
//   - Luma weights and shift for the BT.601-style mono conversion.
//   - Width of the scanline darkening level.
//   - End-to-end pipeline latency, so benches and neighbours can align.
//   - expand(): widens a left-justified DW-bit colour to 8 bits.
package video_fx_pkg;

  localparam int unsigned LUMA_KR    = 5;
  localparam int unsigned LUMA_KG    = 9;
  localparam int unsigned LUMA_KB    = 2;
  localparam int unsigned LUMA_SHIFT = 4;

  localparam int unsigned SCAN_W     = 4;
  localparam int unsigned PIPE_LAT   = 3;

  // The input value sits in the top dw bits of c_left. Its bits are
  // repeated end-to-end down to bit 0, so full scale maps to 0xFF and
  // zero maps to 0x00 for every depth.
  function automatic logic [7:0] expand(input logic [7:0] c_left, input int dw);
    logic [7:0] e;
    e = '0;
    for (int i = 0; i < 8; i++) begin
      e[3'(7 - i)] = c_left[3'(7 - (i % dw))];
    end
    return e;
  endfunction

endpackage

// File: rtl/video_fx_scale.sv
// Multiply-shift unit for scanline darkening, one per colour channel.
// Ports:
//   c  in  8  colour channel
//   f  in  5  weight in sixteenths, 16 = unity
//   y  out 8  (c * f) >> 4
module video_fx_scale (
  input  logic [7:0] c,
  input  logic [4:0] f,
  output logic [7:0] y
);

  // The product of an 8-bit value and a weight of at most 16 fits in 12
  // bits, and after the shift by 4 it always fits back into 8.
  function automatic logic [7:0] mul_shift(input logic [7:0] v, input logic [4:0] w);
    logic [11:0] p;
    p = 12'(v) * 12'(w);
    return 8'(p >> 4);
  endfunction

  assign y = mul_shift(c, f);

endmodule

// File: rtl/video_mixer_fx.sv
// Scanline / mono video mixer with a fixed 3-cycle pipeline.
// Takes selected RGB + sync/blank, expands colour depth to 8 bits,
// optionally converts to luminance, darkens alternate lines and
// generates a data enable. Every output is delayed by the same 3 cycles.
// Ports:
//   clk_sys                 system clock, rising edge
//   reset_n                 synchronous active-low reset
//   ce_pix                  pixel clock enable, delayed to ce_pix_out
//   R, G, B                 DATA_W-bit input colour
//   HSync, VSync            positive sync pulses
//   HBlank, VBlank          positive blanking
//   mono                    luminance on all three channels
//   scanlines_en            enable scanline darkening
//   scan_level              darkening in sixteenths (0 = none)
//   scan_phase              0 darkens odd lines, 1 darkens even lines
//   ce_pix_out              delayed ce_pix
//   VGA_R, VGA_G, VGA_B     8-bit output colour
//   VGA_HS, VGA_VS, VGA_DE  output sync and data enable
module video_mixer_fx
  import video_fx_pkg::*;
#(
  parameter int DATA_W     = 8,
  parameter bit BLANK_ZERO = 1'b1
) (
  input  logic              clk_sys,
  input  logic              reset_n,
  input  logic              ce_pix,
  input  logic [DATA_W-1:0] R,
  input  logic [DATA_W-1:0] G,
  input  logic [DATA_W-1:0] B,
  input  logic              HSync,
  input  logic              VSync,
  input  logic              HBlank,
  input  logic              VBlank,
  input  logic              mono,
  input  logic              scanlines_en,
  input  logic [3:0]        scan_level,
  input  logic              scan_phase,
  output logic              ce_pix_out,
  output logic [7:0]        VGA_R,
  output logic [7:0]        VGA_G,
  output logic [7:0]        VGA_B,
  output logic              VGA_HS,
  output logic              VGA_VS,
  output logic              VGA_DE
);

  localparam logic [4:0] SCALE_ONE = 5'(1 << SCAN_W);

  function automatic logic [7:0] luma_y(input logic [7:0] r, input logic [7:0] g,
                                        input logic [7:0] b);
    logic [11:0] s;
    s = 12'(LUMA_KR) * 12'(r) + 12'(LUMA_KG) * 12'(g) + 12'(LUMA_KB) * 12'(b);
    return 8'(s >> LUMA_SHIFT);
  endfunction

  logic [7:0] r_left, g_left, b_left;
  logic       hs_q, vs_q, hde_q, toggle;
  logic       hs_fall, vs_fall, hde, hde_rise, hde_fall;
  logic       darken_in, de_next;

  logic [7:0]        r_p0, g_p0, b_p0;
  logic              hs_p0, vs_p0, de_p0, vld_p0, dk_p0, mono_p0;
  logic [SCAN_W-1:0] lvl_p0;

  logic [7:0] r_p1, g_p1, b_p1;
  logic       hs_p1, vs_p1, de_p1, vld_p1;
  logic [4:0] fac_p1;
  logic [7:0] r_sc, g_sc, b_sc;

  logic [7:0] r_p2, g_p2, b_p2;
  logic       hs_p2, vs_p2, de_p2, vld_p2;

  // Left-justify the input so expand() sees the value in its top bits.
  assign r_left = 8'(R) << (8 - DATA_W);
  assign g_left = 8'(G) << (8 - DATA_W);
  assign b_left = 8'(B) << (8 - DATA_W);

  assign hs_fall  = hs_q & ~HSync;
  assign vs_fall  = vs_q & ~VSync;
  assign hde      = ~HBlank;
  assign hde_rise = hde & ~hde_q;
  assign hde_fall = ~hde & hde_q;

  assign darken_in = scanlines_en & (toggle ^ scan_phase) & (scan_level != '0);

  // VBlank is only looked at when the line starts; DE then holds until
  // the line ends, so mid-line VBlank changes wait for the next line.
  always_comb begin
    de_next = de_p0;
    if (hde_rise) begin
      de_next = ~VBlank;
    end else if (hde_fall) begin
      de_next = 1'b0;
    end
  end

  // ---- stage 1: edge detect, line toggle, expand, sample controls ----
  always_ff @(posedge clk_sys) begin
    if (!reset_n) begin
      hs_q    <= 1'b0;
      vs_q    <= 1'b0;
      hde_q   <= 1'b0;
      toggle  <= 1'b0;
      r_p0    <= '0;
      g_p0    <= '0;
      b_p0    <= '0;
      hs_p0   <= 1'b0;
      vs_p0   <= 1'b0;
      de_p0   <= 1'b0;
      vld_p0  <= 1'b0;
      dk_p0   <= 1'b0;
      mono_p0 <= 1'b0;
      lvl_p0  <= '0;
    end else begin
      hs_q  <= HSync;
      vs_q  <= VSync;
      hde_q <= hde;
      // Frame start takes priority so line 0 always begins undarkened
      // relative to scan_phase, even if HSync falls in the same cycle.
      if (vs_fall) begin
        toggle <= 1'b0;
      end else if (hs_fall) begin
        toggle <= ~toggle;
      end
      r_p0    <= expand(r_left, DATA_W);
      g_p0    <= expand(g_left, DATA_W);
      b_p0    <= expand(b_left, DATA_W);
      hs_p0   <= HSync;
      vs_p0   <= VSync;
      de_p0   <= de_next;
      vld_p0  <= ce_pix;
      dk_p0   <= darken_in;
      mono_p0 <= mono;
      lvl_p0  <= scan_level;
    end
  end

  // ---- stage 2: mono conversion, darkening weight ----
  always_ff @(posedge clk_sys) begin
    if (!reset_n) begin
      r_p1   <= '0;
      g_p1   <= '0;
      b_p1   <= '0;
      hs_p1  <= 1'b0;
      vs_p1  <= 1'b0;
      de_p1  <= 1'b0;
      vld_p1 <= 1'b0;
      fac_p1 <= SCALE_ONE;
    end else begin
      if (mono_p0) begin
        r_p1 <= luma_y(r_p0, g_p0, b_p0);
        g_p1 <= luma_y(r_p0, g_p0, b_p0);
        b_p1 <= luma_y(r_p0, g_p0, b_p0);
      end else begin
        r_p1 <= r_p0;
        g_p1 <= g_p0;
        b_p1 <= b_p0;
      end
      hs_p1  <= hs_p0;
      vs_p1  <= vs_p0;
      de_p1  <= de_p0;
      vld_p1 <= vld_p0;
      fac_p1 <= dk_p0 ? (SCALE_ONE - 5'(lvl_p0)) : SCALE_ONE;
    end
  end

  video_fx_scale u_scale_r (.c(r_p1), .f(fac_p1), .y(r_sc));
  video_fx_scale u_scale_g (.c(g_p1), .f(fac_p1), .y(g_sc));
  video_fx_scale u_scale_b (.c(b_p1), .f(fac_p1), .y(b_sc));

  // ---- stage 3: darken, blank forcing, output registers ----
  always_ff @(posedge clk_sys) begin
    if (!reset_n) begin
      r_p2   <= '0;
      g_p2   <= '0;
      b_p2   <= '0;
      hs_p2  <= 1'b0;
      vs_p2  <= 1'b0;
      de_p2  <= 1'b0;
      vld_p2 <= 1'b0;
    end else begin
      if (BLANK_ZERO && !de_p1) begin
        r_p2 <= '0;
        g_p2 <= '0;
        b_p2 <= '0;
      end else begin
        r_p2 <= r_sc;
        g_p2 <= g_sc;
        b_p2 <= b_sc;
      end
      hs_p2  <= hs_p1;
      vs_p2  <= vs_p1;
      de_p2  <= de_p1;
      vld_p2 <= vld_p1;
    end
  end

  assign VGA_R      = r_p2;
  assign VGA_G      = g_p2;
  assign VGA_B      = b_p2;
  assign VGA_HS     = hs_p2;
  assign VGA_VS     = vs_p2;
  assign VGA_DE     = de_p2;
  assign ce_pix_out = vld_p2;

endmodule

// File: tb/tb_video_mixer_fx.sv
module tb_video_mixer_fx;
  import video_fx_pkg::*;

  logic       clk_sys = 1'b0;
  logic       reset_n;
  logic       ce_pix;
  logic [7:0] R, G, B;
  logic [3:0] r4, g4, b4;
  logic [2:0] r3, g3, b3;
  logic       HSync, VSync, HBlank, VBlank;
  logic       mono, scanlines_en, scan_phase;
  logic [3:0] scan_level;

  logic       ce_pix_out, VGA_HS, VGA_VS, VGA_DE;
  logic [7:0] VGA_R, VGA_G, VGA_B;
  logic       ce4, hs4, vs4, de4, ce3, hs3, vs3, de3;
  logic [7:0] r4o, g4o, b4o, r3o, g3o, b3o;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk_sys = ~clk_sys;

  video_mixer_fx #(.DATA_W(8), .BLANK_ZERO(1'b1)) dut (
    .clk_sys(clk_sys), .reset_n(reset_n), .ce_pix(ce_pix),
    .R(R), .G(G), .B(B),
    .HSync(HSync), .VSync(VSync), .HBlank(HBlank), .VBlank(VBlank),
    .mono(mono), .scanlines_en(scanlines_en), .scan_level(scan_level),
    .scan_phase(scan_phase), .ce_pix_out(ce_pix_out),
    .VGA_R(VGA_R), .VGA_G(VGA_G), .VGA_B(VGA_B),
    .VGA_HS(VGA_HS), .VGA_VS(VGA_VS), .VGA_DE(VGA_DE)
  );

  video_mixer_fx #(.DATA_W(4), .BLANK_ZERO(1'b1)) dut4 (
    .clk_sys(clk_sys), .reset_n(reset_n), .ce_pix(ce_pix),
    .R(r4), .G(g4), .B(b4),
    .HSync(HSync), .VSync(VSync), .HBlank(HBlank), .VBlank(VBlank),
    .mono(mono), .scanlines_en(scanlines_en), .scan_level(scan_level),
    .scan_phase(scan_phase), .ce_pix_out(ce4),
    .VGA_R(r4o), .VGA_G(g4o), .VGA_B(b4o),
    .VGA_HS(hs4), .VGA_VS(vs4), .VGA_DE(de4)
  );

  video_mixer_fx #(.DATA_W(3), .BLANK_ZERO(1'b1)) dut3 (
    .clk_sys(clk_sys), .reset_n(reset_n), .ce_pix(ce_pix),
    .R(r3), .G(g3), .B(b3),
    .HSync(HSync), .VSync(VSync), .HBlank(HBlank), .VBlank(VBlank),
    .mono(mono), .scanlines_en(scanlines_en), .scan_level(scan_level),
    .scan_phase(scan_phase), .ce_pix_out(ce3),
    .VGA_R(r3o), .VGA_G(g3o), .VGA_B(b3o),
    .VGA_HS(hs3), .VGA_VS(vs3), .VGA_DE(de3)
  );

  typedef struct {
    logic [7:0] r, g, b;
    logic       mono, en;
    logic [3:0] lvl;
    logic       ph;
    logic [7:0] er, eg, eb;
  } vec_t;

  vec_t vecs [12];
  logic hs_pat [8];
  logic vs_pat [8];
  logic ce_pat [8];

  task automatic tick();
    @(posedge clk_sys);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic chk_rgb(input string name, input logic [7:0] er, input logic [7:0] eg,
                         input logic [7:0] eb);
    chk({name, "_r"}, 32'(VGA_R), 32'(er));
    chk({name, "_g"}, 32'(VGA_G), 32'(eg));
    chk({name, "_b"}, 32'(VGA_B), 32'(eb));
  endtask

  task automatic chk_zero(input string name);
    chk_rgb(name, 8'h00, 8'h00, 8'h00);
    chk({name, "_hs"}, 32'(VGA_HS), 32'd0);
    chk({name, "_vs"}, 32'(VGA_VS), 32'd0);
    chk({name, "_de"}, 32'(VGA_DE), 32'd0);
    chk({name, "_ce"}, 32'(ce_pix_out), 32'd0);
  endtask

  task automatic hs_pulse();
    HSync = 1'b1;
    tick();
    HSync = 1'b0;
    tick();
  endtask

  initial begin
    //         r      g      b      mono  en    lvl    ph    er     eg     eb
    vecs[0]  = '{8'h12, 8'h34, 8'h56, 1'b0, 1'b0, 4'd0,  1'b0, 8'h12, 8'h34, 8'h56};
    vecs[1]  = '{8'hFF, 8'h00, 8'h00, 1'b1, 1'b0, 4'd0,  1'b0, 8'h4F, 8'h4F, 8'h4F};
    vecs[2]  = '{8'hFF, 8'hFF, 8'hFF, 1'b1, 1'b0, 4'd0,  1'b0, 8'hFF, 8'hFF, 8'hFF};
    vecs[3]  = '{8'h00, 8'hFF, 8'h00, 1'b1, 1'b0, 4'd0,  1'b0, 8'h8F, 8'h8F, 8'h8F};
    vecs[4]  = '{8'h00, 8'h00, 8'hFF, 1'b1, 1'b0, 4'd0,  1'b0, 8'h1F, 8'h1F, 8'h1F};
    vecs[5]  = '{8'h10, 8'h20, 8'h30, 1'b1, 1'b0, 4'd0,  1'b0, 8'h1D, 8'h1D, 8'h1D};
    vecs[6]  = '{8'hC8, 8'hC8, 8'hC8, 1'b0, 1'b1, 4'd8,  1'b1, 8'h64, 8'h64, 8'h64};
    vecs[7]  = '{8'hC8, 8'hC8, 8'hC8, 1'b0, 1'b1, 4'd8,  1'b0, 8'hC8, 8'hC8, 8'hC8};
    vecs[8]  = '{8'hFF, 8'h80, 8'h10, 1'b0, 1'b1, 4'd15, 1'b1, 8'h0F, 8'h08, 8'h01};
    vecs[9]  = '{8'hFF, 8'h80, 8'h10, 1'b0, 1'b1, 4'd0,  1'b1, 8'hFF, 8'h80, 8'h10};
    vecs[10] = '{8'hFF, 8'h80, 8'h10, 1'b0, 1'b0, 4'd8,  1'b1, 8'hFF, 8'h80, 8'h10};
    vecs[11] = '{8'hFF, 8'hFF, 8'hFF, 1'b1, 1'b1, 4'd4,  1'b1, 8'hBF, 8'hBF, 8'hBF};

    hs_pat = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
    vs_pat = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    ce_pat = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};

    // Reset with live-looking inputs: nothing may leak through.
    reset_n = 1'b0;
    ce_pix = 1'b1;
    R = 8'h12; G = 8'h34; B = 8'h56;
    r4 = 4'hA; g4 = 4'h5; b4 = 4'hF;
    r3 = 3'b101; g3 = 3'b000; b3 = 3'b111;
    HSync = 1'b1; VSync = 1'b0; HBlank = 1'b0; VBlank = 1'b0;
    mono = 1'b0; scanlines_en = 1'b0; scan_level = 4'd0; scan_phase = 1'b0;
    tick();
    tick();
    chk_zero("reset");

    reset_n = 1'b1;
    tick();
    tick();
    chk("post_reset_r_still0", 32'(VGA_R), 32'd0);
    chk("post_reset_de_still0", 32'(VGA_DE), 32'd0);
    tick();
    chk_rgb("passthru", 8'h12, 8'h34, 8'h56);
    chk("passthru_hs", 32'(VGA_HS), 32'd1);
    chk("passthru_vs", 32'(VGA_VS), 32'd0);
    chk("passthru_de", 32'(VGA_DE), 32'd1);
    chk("passthru_ce", 32'(ce_pix_out), 32'd1);

    chk("exp4_r", 32'(r4o), 32'hAA);
    chk("exp4_g", 32'(g4o), 32'h55);
    chk("exp4_b", 32'(b4o), 32'hFF);
    chk("exp3_r", 32'(r3o), 32'hB6);
    chk("exp3_g", 32'(g3o), 32'h00);
    chk("exp3_b", 32'(b3o), 32'hFF);

    // HS / VS / ce_pix_out follow their inputs exactly PIPE_LAT cycles late.
    for (int i = 0; i < 10; i++) begin
      if (i < 8) begin
        HSync  = hs_pat[i];
        VSync  = vs_pat[i];
        ce_pix = ce_pat[i];
      end
      tick();
      if (i >= 2) begin
        chk("hs_delay", 32'(VGA_HS), 32'(hs_pat[i-2]));
        chk("vs_delay", 32'(VGA_VS), 32'(vs_pat[i-2]));
        chk("ce_delay", 32'(ce_pix_out), 32'(ce_pat[i-2]));
      end
    end
    ce_pix = 1'b1;

    // Start of frame: toggle cleared, HSync then held low for the table.
    HSync = 1'b0;
    VSync = 1'b1;
    tick();
    VSync = 1'b0;
    tick();

    for (int i = 0; i < 12; i++) begin
      R = vecs[i].r; G = vecs[i].g; B = vecs[i].b;
      mono = vecs[i].mono; scanlines_en = vecs[i].en;
      scan_level = vecs[i].lvl; scan_phase = vecs[i].ph;
      repeat (PIPE_LAT) tick();
      chk_rgb($sformatf("vec%0d", i), vecs[i].er, vecs[i].eg, vecs[i].eb);
    end

    // Scanlines across lines: level 8, phase 0, constant 0xC8.
    R = 8'hC8; G = 8'hC8; B = 8'hC8;
    mono = 1'b0; scanlines_en = 1'b1; scan_level = 4'd8; scan_phase = 1'b0;
    HSync = 1'b1;
    VSync = 1'b1;
    tick();
    VSync = 1'b0;
    tick();
    repeat (PIPE_LAT) tick();
    chk_rgb("line0_ph0", 8'hC8, 8'hC8, 8'hC8);
    HSync = 1'b0;
    tick();
    repeat (PIPE_LAT) tick();
    chk_rgb("line1_ph0", 8'h64, 8'h64, 8'h64);
    hs_pulse();
    repeat (PIPE_LAT) tick();
    chk_rgb("line2_ph0", 8'hC8, 8'hC8, 8'hC8);
    scan_phase = 1'b1;
    repeat (PIPE_LAT) tick();
    chk_rgb("line2_ph1", 8'h64, 8'h64, 8'h64);
    hs_pulse();
    repeat (PIPE_LAT) tick();
    chk_rgb("line3_ph1", 8'hC8, 8'hC8, 8'hC8);
    scan_level = 4'd0;
    repeat (PIPE_LAT) tick();
    chk_rgb("line3_lvl0", 8'hC8, 8'hC8, 8'hC8);
    scan_level = 4'd8;
    scan_phase = 1'b0;

    // Toggle is 1 here; one more line brings it to 0, then HSync and
    // VSync fall together and the toggle must stay 0.
    hs_pulse();
    HSync = 1'b1;
    VSync = 1'b1;
    tick();
    HSync = 1'b0;
    VSync = 1'b0;
    tick();
    repeat (PIPE_LAT) tick();
    chk_rgb("hs_vs_same_cycle", 8'hC8, 8'hC8, 8'hC8);

    // Mid-frame reset on a darkened line: toggle must restart at 0.
    hs_pulse();
    repeat (PIPE_LAT) tick();
    chk_rgb("pre_reset_line1", 8'h64, 8'h64, 8'h64);
    reset_n = 1'b0;
    tick();
    chk_zero("midframe_reset");
    reset_n = 1'b1;
    repeat (PIPE_LAT) tick();
    chk_rgb("after_reset_toggle0", 8'hC8, 8'hC8, 8'hC8);
    chk("after_reset_de", 32'(VGA_DE), 32'd1);

    // DE falls with HBlank, aligned to colour, and colour is blanked.
    HBlank = 1'b1;
    tick();
    tick();
    chk("de_before_lat", 32'(VGA_DE), 32'd1);
    tick();
    chk("de_hblank", 32'(VGA_DE), 32'd0);
    chk_rgb("blank_hblank", 8'h00, 8'h00, 8'h00);

    // Line starts inside VBlank; VBlank ends mid-line, DE stays 0.
    VBlank = 1'b1;
    tick();
    HBlank = 1'b0;
    tick();
    VBlank = 1'b0;
    tick();
    repeat (PIPE_LAT) tick();
    chk("de_vblank_midline", 32'(VGA_DE), 32'd0);
    chk_rgb("blank_midline", 8'h00, 8'h00, 8'h00);

    // Next line start picks up the cleared VBlank.
    HBlank = 1'b1;
    tick();
    HBlank = 1'b0;
    tick();
    repeat (PIPE_LAT) tick();
    chk("de_next_line", 32'(VGA_DE), 32'd1);
    chk_rgb("active_next_line", 8'hC8, 8'hC8, 8'hC8);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
